// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: iterative AES InvSubBytes engine, LANES inverse S-boxes applied per RUN cycle.
// Optional feature macro INV_SUB_BYTES_SELFCHECK_EN: forward S-box re-check per lane with sticky err.
module inv_sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy,
    output logic         err
);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [3:0] LAST_IDX = 4'(16 - LANES);
    localparam logic [3:0] IDX_STEP = 4'(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 as the product of a^(2^k) for k = 1..7; zero stays zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int unsigned k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] a;
        c = 8'h05;
        for (int unsigned i = 0; i < 8; i++) begin
            a[3'(i)] = b[3'(i + 2)] ^ b[3'(i + 5)] ^ b[3'(i + 7)] ^ c[3'(i)];
        end
        return gf_inv(a);
    endfunction

`ifdef INV_SUB_BYTES_SELFCHECK_EN
    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [7:0] c;
        logic [7:0] x;
        logic [7:0] s;
        c = 8'h63;
        x = gf_inv(b);
        for (int unsigned i = 0; i < 8; i++) begin
            s[3'(i)] = x[3'(i)] ^ x[3'(i + 4)] ^ x[3'(i + 5)] ^ x[3'(i + 6)] ^ x[3'(i + 7)] ^ c[3'(i)];
        end
        return s;
    endfunction
`endif

    state_t        r_state;
    state_t        w_next_state;
    logic [127:0]  r_work;
    logic [127:0]  r_out;
    logic [3:0]    r_idx;
    logic          w_last;
    logic [127:0]  w_work_next;
    logic [7:0]    w_bytes    [16];
    logic [7:0]    w_bytes_nx [16];
    logic [7:0]    w_lane_in  [LANES];
    logic [7:0]    w_lane_out [LANES];

    for (genvar k = 0; k < 16; k++) begin : g_pack
        assign w_bytes[k]                  = r_work[127-8*k -: 8];
        assign w_work_next[127-8*k -: 8]   = w_bytes_nx[k];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_in[l]  = w_bytes[r_idx + 4'(l)];
        assign w_lane_out[l] = inv_sbox(w_lane_in[l]);
    end

    always_comb begin
        w_bytes_nx = w_bytes;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_bytes_nx[r_idx + 4'(l)] = w_lane_out[l];
        end
    end

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next_state = S_RUN;
            S_RUN:   if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = !rst;
            S_RUN:   busy = 1'b1;
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // state_out is a separate register so it holds the previous result while the next block runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_out  <= '0;
            r_idx  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_work <= state_in;
                    r_idx  <= '0;
                end
                S_RUN: begin
                    r_work <= w_work_next;
                    if (w_last) r_out <= w_work_next;
                    else        r_idx <= r_idx + IDX_STEP;
                end
                default: ;
            endcase
        end
    end

    assign state_out = r_out;

`ifdef INV_SUB_BYTES_SELFCHECK_EN
    logic [LANES-1:0] w_chk_bad;
    logic             r_err;

    for (genvar l = 0; l < LANES; l++) begin : g_chk
        assign w_chk_bad[l] = (fwd_sbox(w_lane_out[l]) != w_lane_in[l]);
    end

    always_ff @(posedge clk) begin
        if (rst)                                   r_err <= 1'b0;
        else if (r_state == S_RUN && |w_chk_bad)   r_err <= 1'b1;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq with LANES = 4, 1 and 16 instances side by side.
module tb_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   iv;
    logic [127:0] state_in;
    logic         out_ready;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [2:0]   bz;
    logic [2:0]   er;
    logic [127:0] so [3];

    int checks   = 0;
    int failures = 0;

    logic [7:0] fs  [256];
    logic [7:0] isb [256];

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .state_in(state_in),
        .out_valid(ov[0]), .out_ready(out_ready), .state_out(so[0]), .busy(bz[0]), .err(er[0])
    );
    inv_sub_bytes_seq #(.LANES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .state_in(state_in),
        .out_valid(ov[1]), .out_ready(out_ready), .state_out(so[1]), .busy(bz[1]), .err(er[1])
    );
    inv_sub_bytes_seq #(.LANES(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .state_in(state_in),
        .out_valid(ov[2]), .out_ready(out_ready), .state_out(so[2]), .busy(bz[2]), .err(er[2])
    );

    function automatic logic [7:0] m_gfmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] m_affine(input logic [7:0] x);
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int i = 0; i < 8; i++) begin
            s[3'(i)] = x[3'(i)] ^ x[3'(i + 4)] ^ x[3'(i + 5)] ^ x[3'(i + 6)] ^ x[3'(i + 7)] ^ c[3'(i)];
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [1:0] s, input logic [127:0] din);
        state_in = din;
        iv[s]    = 1'b1;
        step();
        iv[s]    = 1'b0;
    endtask

    task automatic wait_valid(input logic [1:0] s, output int cyc, output int bc);
        cyc = 0;
        bc  = int'(bz[s]);
        while (ov[s] !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
            bc += int'(bz[s]);
        end
    endtask

    task automatic run_block(input logic [1:0] s, input logic [127:0] din, input logic [127:0] exp,
                             input int lat, input string tag);
        int cyc;
        int bc;
        check({tag, " in_ready"}, 128'(ir[s]), 128'(1));
        accept(s, din);
        wait_valid(s, cyc, bc);
        check({tag, " latency"}, 128'(cyc), 128'(lat));
        check({tag, " data"}, so[s], exp);
        check({tag, " busy_cycles"}, 128'(bc), 128'(lat + 1));
        step();
        check({tag, " post ov/ir/busy"}, 128'({ov[s], ir[s], bz[s]}), 128'(3'b010));
        check({tag, " data_hold"}, so[s], exp);
    endtask

    initial begin
        int           cyc;
        int           bc;
        bit           stable;
        logic [7:0]   inv;
        logic [127:0] bo_in;
        logic [127:0] bo_exp;
        logic [127:0] d;
        logic [127:0] e;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (m_gfmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            fs[x] = m_affine(inv);
        end
        for (int x = 0; x < 256; x++) isb[fs[x]] = 8'(x);

        rst       = 1'b1;
        iv        = '0;
        state_in  = '0;
        out_ready = 1'b1;
        step();
        step();
        check("reset in_ready", 128'(ir), 128'(0));
        check("reset out_valid", 128'(ov), 128'(0));
        check("reset busy/err", 128'({bz, er}), 128'(0));
        check("reset state_out", so[0] | so[1] | so[2], 128'(0));
        rst = 1'b0;
        step();
        check("post-reset in_ready", 128'(ir), 128'(3'b111));

        run_block(2'd0, {16{8'h63}}, 128'h0,          4, "all63");
        run_block(2'd0, {16{8'h00}}, {16{8'h52}},     4, "all00");
        run_block(2'd0, {16{8'h7C}}, {16{8'h01}},     4, "all7C");
        run_block(2'd0, {16{8'h16}}, {16{8'hFF}},     4, "all16");

        bo_in  = {8'h63, 8'h7C, 8'h16, 8'hED, {12{8'h63}}};
        bo_exp = {8'h00, 8'h01, 8'hFF, 8'h53, {12{8'h00}}};
        run_block(2'd0, bo_in, bo_exp, 4, "order L4");

        out_ready = 1'b0;
        accept(2'd0, {16{8'h7C}});
        wait_valid(2'd0, cyc, bc);
        check("bp latency", 128'(cyc), 128'(4));
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iv[0] = i[0];
            step();
            if (ov[0] !== 1'b1 || so[0] !== {16{8'h01}} || ir[0] !== 1'b0) stable = 1'b0;
        end
        iv[0] = 1'b0;
        check("bp hold stable", 128'(stable), 128'(1));
        out_ready = 1'b1;
        step();
        check("bp release ov/ir", 128'({ov[0], ir[0]}), 128'(2'b01));
        check("bp release data", so[0], {16{8'h01}});
        step();
        check("bp no reaccept", 128'({ov[0], bz[0]}), 128'(0));

        accept(2'd0, {16{8'hED}});
        step();
        rst = 1'b1;
        step();
        check("midrun rst ov/ir/busy", 128'({ov[0], ir[0], bz[0]}), 128'(0));
        check("midrun rst state_out", so[0], 128'(0));
        rst = 1'b0;
        step();
        check("after rst in_ready", 128'(ir[0]), 128'(1));
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (ov[0] !== 1'b0) stable = 1'b0;
            step();
        end
        check("discarded block no out_valid", 128'(stable), 128'(1));
        run_block(2'd0, {16{8'h63}}, 128'h0, 4, "after rst all63");

        run_block(2'd1, bo_in, bo_exp, 16, "order L1");
        run_block(2'd2, bo_in, bo_exp, 1,  "order L16");

        for (int b = 0; b < 16; b++) begin
            d = '0;
            e = '0;
            for (int k = 0; k < 16; k++) begin
                d = {d[119:0], 8'(16 * b + k)};
                e = {e[119:0], isb[16 * b + k]};
            end
            run_block(2'd0, d, e, 4, "exhaustive");
            check("exhaustive err", 128'(er[0]), 128'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
